// File: rtl/chan_packet_time_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chan_packet_time_pkg
// Purpose  : Shared constants and PPS window helpers for the channel-packet
//            timekeeper.
// Revision : 1.0 - initial release
// ============================================================================
package chan_packet_time_pkg;

  // Lock state encoding, also visible on state_out
  localparam logic [1:0] ST_FREE   = 2'b00;
  localparam logic [1:0] ST_ARMED  = 2'b01;
  localparam logic [1:0] ST_LOCKED = 2'b10;

  // PPS arrived shortly before the boundary: take the boundary now
  function automatic logic pps_is_early(input logic [31:0] ticks,
                                        input logic [31:0] tps,
                                        input logic [31:0] tol);
    return (ticks >= (tps - tol));
  endfunction

  // PPS arrived shortly after the boundary, which has already been taken
  function automatic logic pps_is_late(input logic [31:0] ticks,
                                       input logic [31:0] tol);
    return (ticks <= tol);
  endfunction

  // First tick past the late window: a PPS should have been seen by now
  function automatic logic pps_window_closed(input logic [31:0] ticks,
                                             input logic [31:0] tol);
    return (ticks == (tol + 32'd1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/chan_packet_pps_sync.sv
`default_nettype none
// ============================================================================
// Module   : chan_packet_pps_sync
// Purpose  : Brings the asynchronous 1PPS into the local clock domain and
//            produces a registered one-cycle strobe on its rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module chan_packet_pps_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_pps,
  output logic o_pps_edge
);

  logic r_meta;
  logic r_sync;
  logic r_sync_d;
  logic r_edge;

  // Two-flop synchronizer, edge history and registered edge strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_sync_d <= 1'b0;
      r_edge   <= 1'b0;
    end else begin
      r_meta   <= i_pps;
      r_sync   <= r_meta;
      r_sync_d <= r_sync;
      r_edge   <= r_sync & ~r_sync_d;
    end
  end

  assign o_pps_edge = r_edge;

endmodule
`default_nettype wire

// File: rtl/chan_packet_time_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chan_packet_time_ctrl
// Purpose  : Seconds/ticks time base for channel packets, aligned to an
//            external 1PPS; software-loaded seconds take effect on next PPS.
// Revision : 1.0 - initial release
// ============================================================================
module chan_packet_time_ctrl
  import chan_packet_time_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 256000000,
  parameter int unsigned PPS_TOL       = 16,
  parameter int unsigned ERR_CNT_W     = 16
) (
  input  logic                 user_clk,
  input  logic                 user_rst,
  input  logic                 pps_in,
  input  logic [31:0]          sec_load_val,
  input  logic                 sec_load_req,
  output logic [31:0]          seconds,
  output logic [31:0]          ticks,
  output logic                 sec_pulse,
  output logic [1:0]           state_out,
  output logic                 pps_missing,
  output logic [ERR_CNT_W-1:0] pps_err_cnt
);

  localparam logic [31:0] c_tps    = 32'(TICKS_PER_SEC);
  localparam logic [31:0] c_tps_m1 = 32'(TICKS_PER_SEC - 1);
  localparam logic [31:0] c_tol    = 32'(PPS_TOL);

  logic [1:0]           r_state;
  logic [31:0]          r_seconds;
  logic [31:0]          r_ticks;
  logic                 r_pulse;
  logic [31:0]          r_pending;
  logic                 r_missing;
  logic                 r_pps_seen;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 r_load_q;
  logic                 r_load_qq;

  logic                 w_pps_edge;
  logic                 w_load_edge;
  logic                 w_nat_wrap;
  logic [1:0]           w_nxt_state;
  logic [31:0]          w_nxt_seconds;
  logic [31:0]          w_nxt_ticks;
  logic                 w_nxt_pulse;
  logic [31:0]          w_nxt_pending;
  logic                 w_nxt_missing;
  logic                 w_nxt_seen;
  logic                 w_err_inc;

  chan_packet_pps_sync u_pps_sync (
    .clk        (user_clk),
    .rst        (user_rst),
    .i_pps      (pps_in),
    .o_pps_edge (w_pps_edge)
  );

  // Register the software request twice so its rising edge is fully synchronous
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_load_q  <= 1'b0;
      r_load_qq <= 1'b0;
    end else begin
      r_load_q  <= sec_load_req;
      r_load_qq <= r_load_q;
    end
  end

  assign w_load_edge = r_load_q & ~r_load_qq;

  // Lock state register
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_state <= ST_FREE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next state and next time-base values; a load is applied last so it
  // overrides the state chosen by the PPS rules
  always_comb begin
    w_nat_wrap    = (r_ticks == c_tps_m1);
    w_nxt_ticks   = w_nat_wrap ? 32'd0 : (r_ticks + 32'd1);
    w_nxt_seconds = w_nat_wrap ? (r_seconds + 32'd1) : r_seconds;
    w_nxt_pulse   = w_nat_wrap;
    w_nxt_state   = r_state;
    w_nxt_pending = r_pending;
    w_nxt_missing = r_missing;
    w_err_inc     = 1'b0;
    w_nxt_seen    = r_pps_seen;

    if (w_pps_edge) begin
      w_nxt_seen = 1'b1;
    end else if (w_nat_wrap) begin
      w_nxt_seen = 1'b0;
    end

    case (r_state)
      ST_FREE: begin
        w_nxt_state = ST_FREE;
      end
      ST_ARMED: begin
        if (w_pps_edge) begin
          w_nxt_seconds = r_pending;
          w_nxt_ticks   = 32'd0;
          w_nxt_pulse   = 1'b1;
          w_nxt_state   = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (w_pps_edge) begin
          if (pps_is_early(r_ticks, c_tps, c_tol)) begin
            // Also covers a PPS coinciding with the natural wrap: one increment
            w_nxt_ticks   = 32'd0;
            w_nxt_seconds = r_seconds + 32'd1;
            w_nxt_pulse   = 1'b1;
          end else if (pps_is_late(r_ticks, c_tol)) begin
            w_nxt_ticks   = 32'd0;
            w_nxt_seconds = r_seconds;
            w_nxt_pulse   = 1'b0;
          end else begin
            w_err_inc   = 1'b1;
            w_nxt_state = ST_FREE;
          end
        end else if (pps_window_closed(r_ticks, c_tol) && !r_pps_seen) begin
          w_nxt_missing = 1'b1;
          w_err_inc     = 1'b1;
          w_nxt_state   = ST_FREE;
        end
      end
      default: begin
        w_nxt_state = ST_FREE;
      end
    endcase

    if (w_load_edge) begin
      w_nxt_pending = sec_load_val;
      w_nxt_missing = 1'b0;
      w_nxt_state   = ST_ARMED;
    end
  end

  // Time base, pending value, flags and saturating error counter
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      r_seconds  <= 32'd0;
      r_ticks    <= 32'd0;
      r_pulse    <= 1'b0;
      r_pending  <= 32'd0;
      r_missing  <= 1'b0;
      r_pps_seen <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_seconds  <= w_nxt_seconds;
      r_ticks    <= w_nxt_ticks;
      r_pulse    <= w_nxt_pulse;
      r_pending  <= w_nxt_pending;
      r_missing  <= w_nxt_missing;
      r_pps_seen <= w_nxt_seen;
      if (w_err_inc && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  // Outputs come straight from registers
  always_comb begin
    seconds     = r_seconds;
    ticks       = r_ticks;
    sec_pulse   = r_pulse;
    state_out   = r_state;
    pps_missing = r_missing;
    pps_err_cnt = r_err_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_chan_packet_time_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chan_packet_time_ctrl
// Purpose  : Scoreboard bench for chan_packet_time_ctrl with TICKS_PER_SEC=100
//            and PPS_TOL=4. Cycle n is n clock edges after reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chan_packet_time_ctrl;
  import chan_packet_time_pkg::*;

  localparam int B = 3;

  logic        user_clk = 1'b0;
  logic        user_rst = 1'b1;
  logic        pps_in = 1'b0;
  logic [31:0] sec_load_val = 32'd0;
  logic        sec_load_req = 1'b0;
  logic [31:0] seconds;
  logic [31:0] ticks;
  logic        sec_pulse;
  logic [1:0]  state_out;
  logic        pps_missing;
  logic [15:0] pps_err_cnt;

  chan_packet_time_ctrl #(
    .TICKS_PER_SEC (100),
    .PPS_TOL       (4),
    .ERR_CNT_W     (16)
  ) dut (
    .user_clk     (user_clk),
    .user_rst     (user_rst),
    .pps_in       (pps_in),
    .sec_load_val (sec_load_val),
    .sec_load_req (sec_load_req),
    .seconds      (seconds),
    .ticks        (ticks),
    .sec_pulse    (sec_pulse),
    .state_out    (state_out),
    .pps_missing  (pps_missing),
    .pps_err_cnt  (pps_err_cnt)
  );

  always #5 user_clk = ~user_clk;

  int cyc = 0;
  always @(posedge user_clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] sec;
    logic [31:0] tk;
    logic [1:0]  st;
    logic        miss;
    logic [15:0] err;
    logic        pulse;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];
  int   checks = 0;
  int   errors = 0;
  exp_t mx;

  task automatic push(input int n, input string nm, input logic [31:0] s,
                      input logic [31:0] tk, input logic [1:0] st,
                      input logic m, input logic [15:0] e, input logic p);
    exp_t x;
    x.cyc = B + n; x.name = nm; x.sec = s; x.tk = tk;
    x.st = st; x.miss = m; x.err = e; x.pulse = p;
    exp_q.push_back(x);
  endtask

  task automatic push_pulse(input int n);
    pulse_q.push_back(B + n);
  endtask

  task automatic wait_n(input int n);
    while (cyc < B + n) @(negedge user_clk);
  endtask

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got %0h expected %0h (cycle %0d)", nm, fld, act, expv, cyc - B);
    end
  endtask

  // Monitor: compares scheduled snapshots and every sec_pulse against the queues
  always @(negedge user_clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mx = exp_q.pop_front();
      if (mx.cyc < cyc) begin
        checks++; errors++;
        $display("FAIL %s: snapshot missed, got none expected cycle %0d", mx.name, mx.cyc - B);
      end else begin
        chk(mx.name, "seconds",   seconds,             mx.sec);
        chk(mx.name, "ticks",     ticks,               mx.tk);
        chk(mx.name, "state",     32'(state_out),      32'(mx.st));
        chk(mx.name, "missing",   32'(pps_missing),    32'(mx.miss));
        chk(mx.name, "err_cnt",   32'(pps_err_cnt),    32'(mx.err));
        chk(mx.name, "sec_pulse", 32'(sec_pulse),      32'(mx.pulse));
      end
    end
    while (pulse_q.size() > 0 && pulse_q[0] < cyc) begin
      checks++; errors++;
      $display("FAIL pulse: got no pulse expected pulse at cycle %0d", pulse_q[0] - B);
      void'(pulse_q.pop_front());
    end
    if (sec_pulse === 1'b1) begin
      checks++;
      if (pulse_q.size() > 0 && pulse_q[0] == cyc) begin
        void'(pulse_q.pop_front());
      end else begin
        errors++;
        $display("FAIL pulse: got pulse at cycle %0d expected none", cyc - B);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and free run
    push(0,   "reset",    32'd0, 32'd0,  ST_FREE, 1'b0, 16'd0, 1'b0);
    push(100, "free_s1",  32'd1, 32'd0,  ST_FREE, 1'b0, 16'd0, 1'b1);
    push(250, "free_250", 32'd2, 32'd50, ST_FREE, 1'b0, 16'd0, 1'b0);
    push_pulse(100);
    push_pulse(200);
    wait_n(0);
    user_rst = 1'b0;
    wait_n(250);

    // Load 0x1000 then PPS: lock on the third edge after pps_in is sampled
    push(255, "armed",   32'd2,      32'd55, ST_ARMED,  1'b0, 16'd0, 1'b0);
    push_pulse(300);
    push_pulse(304);
    push(304, "lock",    32'h1000,   32'd0,  ST_LOCKED, 1'b0, 16'd0, 1'b1);
    push(305, "lock+1",  32'h1000,   32'd1,  ST_LOCKED, 1'b0, 16'd0, 1'b0);
    wait_n(252); sec_load_val = 32'h1000; sec_load_req = 1'b1;
    wait_n(260); sec_load_req = 1'b0;
    wait_n(300); pps_in = 1'b1;
    wait_n(310); pps_in = 1'b0;

    // Early PPS at ticks=97, late PPS at ticks=2
    push_pulse(402);
    push(402, "early",    32'h1001, 32'd0, ST_LOCKED, 1'b0, 16'd0, 1'b1);
    push_pulse(502);
    push(504, "pre_late", 32'h1002, 32'd2, ST_LOCKED, 1'b0, 16'd0, 1'b0);
    push(505, "late",     32'h1002, 32'd0, ST_LOCKED, 1'b0, 16'd0, 1'b0);
    wait_n(398); pps_in = 1'b1;
    wait_n(400); pps_in = 1'b0;
    wait_n(501); pps_in = 1'b1;
    wait_n(503); pps_in = 1'b0;

    // Withheld PPS: decision taken in the ticks=5 cycle
    push_pulse(605);
    push(610, "miss_pre", 32'h1003, 32'd5, ST_LOCKED, 1'b0, 16'd0, 1'b0);
    push(611, "missing",  32'h1003, 32'd6, ST_FREE,   1'b1, 16'd1, 1'b0);
    push(612, "miss_run", 32'h1003, 32'd7, ST_FREE,   1'b1, 16'd1, 1'b0);

    // Re-lock, then out-of-window PPS at ticks=50
    push(623, "rearm",    32'h1003, 32'd18, ST_ARMED,  1'b0, 16'd1, 1'b0);
    push_pulse(654);
    push(654, "relock",   32'h1000, 32'd0,  ST_LOCKED, 1'b0, 16'd1, 1'b1);
    push(705, "oow",      32'h1000, 32'd51, ST_FREE,   1'b0, 16'd2, 1'b0);
    push(706, "oow_run",  32'h1000, 32'd52, ST_FREE,   1'b0, 16'd2, 1'b0);
    push_pulse(754);
    push(754, "free_wrap", 32'h1001, 32'd0, ST_FREE,   1'b0, 16'd2, 1'b1);
    wait_n(620); sec_load_val = 32'h1000; sec_load_req = 1'b1;
    wait_n(625); sec_load_req = 1'b0;
    wait_n(650); pps_in = 1'b1;
    wait_n(655); pps_in = 1'b0;
    wait_n(701); pps_in = 1'b1;
    wait_n(703); pps_in = 1'b0;

    // ARMED with load 0x2000 and PPS in the same cycle, then the next PPS
    push(763, "arm2",     32'h1001, 32'd9, ST_ARMED,  1'b0, 16'd2, 1'b0);
    push_pulse(784);
    push(784, "coincide", 32'h1000, 32'd0, ST_ARMED,  1'b0, 16'd2, 1'b1);
    push_pulse(824);
    push(824, "lock2000", 32'h2000, 32'd0, ST_LOCKED, 1'b0, 16'd2, 1'b1);
    wait_n(760); sec_load_req = 1'b1;
    wait_n(765); sec_load_req = 1'b0;
    wait_n(780); pps_in = 1'b1;
    wait_n(782); pps_in = 1'b0; sec_load_val = 32'h2000; sec_load_req = 1'b1;
    wait_n(787); sec_load_req = 1'b0;
    wait_n(820); pps_in = 1'b1;
    wait_n(822); pps_in = 1'b0;

    // Mid-run reset; a later PPS must find the block FREE with nothing pending
    push(851, "rst_mid",  32'd0, 32'd0, ST_FREE, 1'b0, 16'd0, 1'b0);
    push(860, "post_rst", 32'd0, 32'd9, ST_FREE, 1'b0, 16'd0, 1'b0);
    wait_n(850); user_rst = 1'b1;
    wait_n(851); user_rst = 1'b0;
    wait_n(855); pps_in = 1'b1;
    wait_n(857); pps_in = 1'b0;

    wait_n(870);
    while (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL %s: snapshot never compared, expected cycle %0d", mx.name, mx.cyc - B);
    end
    while (pulse_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL pulse: got no pulse expected pulse at cycle %0d", pulse_q[0] - B);
      void'(pulse_q.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chan_packet_time_ctrl.md
Name: chan_packet_time_ctrl

Overview:
- Timekeeper for channel packets; runs in the user_clk domain.
- Holds the seconds/ticks time base and aligns it to an external 1PPS.
- Software loads the seconds value; the new value takes effect on the next PPS.
- `seconds` drives the data input of the `chan_packet_seconds` software register. `seconds`/`ticks` also feed the channel-packet header builder.

Parameters:
- TICKS_PER_SEC, 256000000: user_clk cycles per second; wrap point of `ticks`.
- PPS_TOL, 16: allowed PPS misalignment in ticks, either side of a second boundary.
- ERR_CNT_W, 16: width of the PPS error counter.

Ports:
- user_clk  in  1  only clock
- user_rst  in  1  synchronous, active-high reset
- pps_in  in  1  external 1PPS, asynchronous, rising edge meaningful
- sec_load_val  in  32  seconds value from the software register
- sec_load_req  in  1  software level; a rising edge arms a load
- seconds  out  32  current seconds
- ticks  out  32  cycles into the current second, 0..TICKS_PER_SEC-1
- sec_pulse  out  1  one-cycle strobe in the cycle ticks becomes 0
- state_out  out  2  00 FREE, 01 ARMED, 10 LOCKED
- pps_missing  out  1  sticky; cleared only by reset or a new load
- pps_err_cnt  out  ERR_CNT_W  saturating count of out-of-window or missing PPS

Behaviour:
- Reset: seconds=0, ticks=0, sec_pulse=0, state=FREE, pps_missing=0, pps_err_cnt=0, pending=0, all sync/edge flops=0.
- PPS path: pps_in → 2-flop synchronizer → rising-edge detect → registered pps_edge.
  - Time outputs update on the 3rd user_clk edge after pps_in is first sampled high.
- Load edge: sec_load_req is registered; a rising edge gives load_edge.
- Normal tick: ticks increments each cycle.
  - At ticks==TICKS_PER_SEC-1: ticks wraps to 0, seconds+1 (mod 2^32), sec_pulse=1. This is the same cycle seconds changes.
  - seconds and ticks always change in the same cycle, so snapshots are coherent.
- FREE: free-running. On load_edge: pending<=sec_load_val, pps_missing<=0, go to ARMED.
- ARMED: free-running.
  - On pps_edge: seconds<=pending, ticks<=0, sec_pulse=1, go to LOCKED.
  - load_edge while ARMED overwrites pending.
- LOCKED: pps_edge is checked against the current ticks:
  - Early, ticks >= TICKS_PER_SEC-PPS_TOL: ticks<=0, seconds+1, sec_pulse=1.
  - Late, ticks <= PPS_TOL: ticks<=0, seconds unchanged, no sec_pulse (the boundary was already taken).
  - Otherwise: pps_err_cnt+1, go to FREE, counting continues undisturbed.
  - Missing PPS: if ticks==PPS_TOL+1 and no pps_edge since the last wrap → pps_missing<=1, pps_err_cnt+1, go to FREE.
  - A pps_seen flag tracks PPS since wrap; it is cleared on every wrap and set by pps_edge.
  - load_edge in LOCKED: pending<=value, go to ARMED. The lock is re-established at the next PPS.
- Simultaneous events:
  - load_edge and pps_edge in the same cycle while ARMED: the PPS applies the old pending; the new value is stored and state stays ARMED.
  - In FREE or LOCKED: the load is taken and the PPS is treated as ARMED-less (FREE/LOCKED rules), then state becomes ARMED.
  - pps_edge coincident with the natural wrap cycle: a single wrap, a single seconds increment.
- pps_err_cnt saturates at all-ones.
- user_rst mid-operation: everything returns to reset values on the next edge. A pending load is discarded.
- No combinational path from any input to any output.

Decomposition:
- Package chan_packet_time_pkg holds:
  - state encoding constants: FREE, ARMED, LOCKED
  - tolerance window helper comparisons, derived from TICKS_PER_SEC/PPS_TOL
- One sub-module: chan_packet_pps_sync (2-flop synchronizer plus registered rising-edge detect, 1-bit in, 1-bit out).

Test Plan (TICKS_PER_SEC=100, PPS_TOL=4):
- Reset, free run 250 cycles → seconds=2, ticks=50; sec_pulse at cycles 100 and 200 only.
- Load 0x1000, then pps_in high at t → on t+3, seconds=0x1000, ticks=0, state=LOCKED, sec_pulse=1.
- LOCKED, PPS when ticks=97 (early) → ticks=0, seconds+1. PPS when ticks=2 (late) → ticks=0, seconds unchanged, err_cnt=0.
- LOCKED, PPS withheld → at ticks=5, pps_missing=1, err_cnt=1, state=FREE, counting continues.
- LOCKED, PPS at ticks=50 → err_cnt+1, state=FREE, ticks continues 51,52.
- ARMED, load_edge (0x2000) and pps_edge in the same cycle → seconds takes the old pending (0x1000), state stays ARMED. The next PPS loads 0x2000.
